// File: rtl/spongent_hash_ctrl_pkg.sv
// spongent_hash_ctrl_pkg
//   Shared definitions for the spongent hash sequencer: FSM state encoding,
//   the padding byte appended after the message, default parameter values
//   and a helper that converts a digest length in bits to bytes.
package spongent_hash_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CRST,
    ST_FETCH,
    ST_FEED,
    ST_GUARD,
    ST_WAIT,
    ST_PAD,
    ST_SQZ_RD,
    ST_SQZ_OUT
  } state_t;

  // A single 1 bit followed by zeros fills exactly one 8-bit rate block.
  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam int DEFAULT_RATE        = 8;
  localparam int DEFAULT_DIGEST_BITS = 128;

  function automatic int digest_bytes(input int bits);
    return bits / 8;
  endfunction

endpackage

// File: rtl/spongent_hash_ctrl.sv
// spongent_hash_ctrl
//   Sequencer for one spongent core. Absorbs 16-bit message words (low byte
//   first) one byte per permutation, appends the padding block, then squeezes
//   the digest and hands it out as 16-bit words (first squeezed byte low).
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   cmd_start, cmd_abort         start a hash (IDLE only) / abandon it
//   busy, done                   not-idle flag, 1-cycle completion pulse
//   msg_data/valid/last/odd      message word stream, msg_ready handshake
//   dig_data/valid, dig_ready    digest word stream
//   core_reset/start/msg_avail   control to the spongent core
//   core_data_in, core_data_out  rate block to / from the core
//   core_busy                    core permutation in progress
module spongent_hash_ctrl
  import spongent_hash_ctrl_pkg::*;
#(
  parameter int RATE        = DEFAULT_RATE,
  parameter int DIGEST_BITS = DEFAULT_DIGEST_BITS
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_start,
  input  logic            cmd_abort,
  output logic            busy,
  output logic            done,
  input  logic [15:0]     msg_data,
  input  logic            msg_valid,
  input  logic            msg_last,
  input  logic            msg_odd,
  output logic            msg_ready,
  output logic [15:0]     dig_data,
  output logic            dig_valid,
  input  logic            dig_ready,
  output logic            core_reset,
  output logic            core_start,
  output logic            core_msg_avail,
  output logic [RATE-1:0] core_data_in,
  input  logic            core_busy,
  input  logic [RATE-1:0] core_data_out
);

  localparam int DIG_BYTES = digest_bytes(DIGEST_BITS);
  localparam int CNT_W     = $clog2(DIG_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIG_BYTES);

  if (RATE != 8) begin : g_rate_check
    $error("spongent_hash_ctrl: only RATE=8 is supported");
  end
  if ((DIGEST_BITS % 16) != 0 || DIGEST_BITS < 16) begin : g_digest_check
    $error("spongent_hash_ctrl: DIGEST_BITS must be a multiple of 16 and >= 16");
  end

  state_t           state, state_d;
  logic [15:0]      word_q;
  logic             last_q, odd_q;
  logic             byte_sel;     // 1 once the high byte of word_q has been fed
  logic             absorbing;    // core is in the absorb phase of this hash
  logic             padded;       // padding block has been fed
  logic             abort_pend;   // CRST was entered through cmd_abort
  logic [CNT_W-1:0] sqz_cnt;
  logic [7:0]       data_q;
  logic [15:0]      dig_q;
  logic             done_q;

  logic accept, feed_hi, feed_pad, capture, finish;

  // Next-state logic and per-cycle strobes. Abort overrides everything,
  // including a message accept or final digest accept in the same cycle.
  always_comb begin
    state_d    = state;
    core_start = 1'b0;
    accept     = 1'b0;
    feed_hi    = 1'b0;
    feed_pad   = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE:  if (cmd_start) state_d = ST_CRST;
      ST_CRST:  state_d = abort_pend ? ST_IDLE : ST_FETCH;
      ST_FETCH: if (msg_valid) begin
        accept  = 1'b1;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        core_start = 1'b1;
        state_d    = ST_GUARD;
      end
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: if (!core_busy) begin
        if (!absorbing || padded) begin
          state_d = ST_SQZ_RD;
        end else if (!byte_sel && !(last_q && odd_q)) begin
          feed_hi = 1'b1;
          state_d = ST_FEED;
        end else if (!last_q) begin
          state_d = ST_FETCH;
        end else begin
          feed_pad = 1'b1;
          state_d  = ST_PAD;
        end
      end
      ST_PAD: begin
        core_start = 1'b1;
        state_d    = ST_GUARD;
      end
      ST_SQZ_RD: begin
        capture = 1'b1;
        // An odd pre-increment count means the high byte just completed a word.
        if (sqz_cnt[0]) begin
          state_d = ST_SQZ_OUT;
        end else begin
          core_start = 1'b1;
          state_d    = ST_GUARD;
        end
      end
      ST_SQZ_OUT: if (dig_ready) begin
        if (sqz_cnt == CNT_LAST) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          core_start = 1'b1;
          state_d    = ST_GUARD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmd_abort) begin
      state_d    = ST_CRST;
      core_start = 1'b0;
      accept     = 1'b0;
      feed_hi    = 1'b0;
      feed_pad   = 1'b0;
      capture    = 1'b0;
      finish     = 1'b0;
    end
  end

  // State register plus the message/digest datapath.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      word_q     <= '0;
      last_q     <= 1'b0;
      odd_q      <= 1'b0;
      byte_sel   <= 1'b0;
      absorbing  <= 1'b0;
      padded     <= 1'b0;
      abort_pend <= 1'b0;
      sqz_cnt    <= '0;
      data_q     <= '0;
      dig_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= finish;
      if (cmd_abort) begin
        abort_pend <= 1'b1;
      end else if (state == ST_CRST) begin
        abort_pend <= 1'b0;
        absorbing  <= 1'b1;
        padded     <= 1'b0;
        sqz_cnt    <= '0;
      end
      if (accept) begin
        word_q   <= msg_data;
        last_q   <= msg_last;
        odd_q    <= msg_odd;
        byte_sel <= 1'b0;
        data_q   <= msg_data[7:0];
      end
      if (feed_hi) begin
        byte_sel <= 1'b1;
        data_q   <= word_q[15:8];
      end
      if (feed_pad) begin
        padded <= 1'b1;
        data_q <= PAD_BYTE;
      end
      if (capture) begin
        absorbing <= 1'b0;
        if (sqz_cnt[0]) dig_q[15:8] <= core_data_out[7:0];
        else            dig_q[7:0]  <= core_data_out[7:0];
        sqz_cnt <= sqz_cnt + CNT_W'(1);
      end
    end
  end

  // msg_avail stays up through GUARD/WAIT so the core sees a stable absorb request.
  assign core_msg_avail = absorbing &&
                          (state == ST_FEED || state == ST_PAD ||
                           state == ST_GUARD || state == ST_WAIT);
  assign core_data_in   = data_q;
  assign core_reset     = !reset_n || (state == ST_CRST);
  assign busy           = (state != ST_IDLE);
  assign done           = done_q;
  assign msg_ready      = (state == ST_FETCH);
  assign dig_valid      = (state == ST_SQZ_OUT);
  assign dig_data       = dig_q;

endmodule

// File: tb/tb_spongent_hash_ctrl.sv
// tb_spongent_hash_ctrl
//   Self-checking bench for spongent_hash_ctrl. A behavioural stand-in for the
//   spongent core mixes a 32-bit state on every start pulse; ref_digest derives
//   the expected digest from the message bytes plus padding.
module tb_spongent_hash_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, cmd_start, cmd_abort;
  logic        busy, done;
  logic [15:0] msg_data;
  logic        msg_valid, msg_last, msg_odd, msg_ready;
  logic [15:0] dig_data;
  logic        dig_valid, dig_ready;
  logic        core_reset, core_start, core_msg_avail;
  logic [7:0]  core_data_in, core_data_out;
  logic        core_busy;

  always #5 clk = ~clk;

  spongent_hash_ctrl #(.RATE(8), .DIGEST_BITS(128)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .busy(busy), .done(done), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_odd(msg_odd), .msg_ready(msg_ready),
    .dig_data(dig_data), .dig_valid(dig_valid), .dig_ready(dig_ready),
    .core_reset(core_reset), .core_start(core_start), .core_msg_avail(core_msg_avail),
    .core_data_in(core_data_in), .core_busy(core_busy), .core_data_out(core_data_out)
  );

  int checks = 0;
  int fails  = 0;

  function automatic logic [31:0] mix(input logic [31:0] x);
    logic [31:0] y;
    y = x * 32'h0019660D + 32'h3C6EF35F;
    return y ^ {y[18:0], y[31:19]};
  endfunction

  // Behavioural core: state update on start, busy for core_lat cycles.
  int          core_lat    = 3;
  int          busy_cnt    = 0;
  logic [31:0] h_state     = '0;
  logic [7:0]  absorbed[$];
  int          sqz_pulses  = 0;
  int          start_count = 0;
  int          done_count  = 0;

  always @(posedge clk) begin
    if (core_reset) begin
      h_state  <= '0;
      busy_cnt <= 0;
      absorbed.delete();
      sqz_pulses = 0;
    end else if (core_start) begin
      if (core_msg_avail) begin
        h_state <= mix(h_state ^ {24'h0, core_data_in});
        absorbed.push_back(core_data_in);
      end else begin
        h_state <= mix(h_state);
        sqz_pulses++;
      end
      start_count++;
      busy_cnt <= core_lat;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (done) done_count++;
  end

  assign core_busy     = (busy_cnt != 0);
  assign core_data_out = h_state[7:0];

  // Reference digest: message bytes + 0x80 absorbed, 16 output bytes.
  function automatic logic [127:0] ref_digest(input logic [95:0] bytes, input int len);
    logic [7:0]   q[$];
    logic [31:0]  h;
    logic [127:0] d;
    for (int k = 0; k < len; k++) q.push_back(bytes[8*k +: 8]);
    q.push_back(8'h80);
    h = '0;
    foreach (q[k]) h = mix(h ^ {24'h0, q[k]});
    d = '0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) h = mix(h);
      d[8*k +: 8] = h[7:0];
    end
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  typedef struct {
    int          len;
    logic [95:0] bytes;
    int          lat;
    int          stall_word;
    int          stall_cycles;
    int          start_word;
    int          exp_absorbs;
    int          exp_sqz;
  } vec_t;

  vec_t vecs[10];

  task automatic sendMessage(input logic [95:0] bytes, input int len, output bit ok);
    int i;
    int n;
    logic [15:0] w;
    bit is_last, is_odd;
    ok = 1;
    i  = 0;
    while (i < len) begin
      is_last = (i + 2 >= len);
      is_odd  = (i + 1 == len);
      w[7:0]  = bytes[8*i +: 8];
      w[15:8] = is_odd ? 8'($urandom) : bytes[8*(i+1) +: 8];
      msg_data  = w;
      msg_valid = 1'b1;
      msg_last  = is_last;
      msg_odd   = is_odd;
      n = 0;
      while (!msg_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!msg_ready) begin
        checkOutput("msg_ready timeout", 0, 1);
        msg_valid = 1'b0;
        ok = 0;
        return;
      end
      checkOutput("accept with core idle", {core_busy, 32'(absorbed.size())}, {1'b0, 32'(i)});
      @(negedge clk);
      i += 2;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_odd   = 1'b0;
  endtask

  task automatic recvDigest(input int stall_word, input int stall_cycles, input int start_word,
                            output logic [127:0] got, output bit ok);
    int n;
    int starts0;
    logic [15:0] held;
    ok  = 1;
    got = '0;
    for (int w = 0; w < 8; w++) begin
      n = 0;
      while (!dig_valid && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (!dig_valid) begin
        checkOutput("dig_valid timeout", 0, 1);
        ok = 0;
        return;
      end
      held    = dig_data;
      starts0 = start_count;
      if (w == start_word) begin
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        checkOutput("start ignored in squeeze", {dig_valid, dig_data}, {1'b1, held});
      end
      if (w == stall_word) begin
        repeat (stall_cycles) begin
          @(negedge clk);
          checkOutput("stall dig stable", {dig_valid, dig_data}, {1'b1, held});
          checkOutput("stall no core_start", start_count, starts0);
        end
      end
      got[16*w +: 16] = dig_data;
      dig_ready = 1'b1;
      @(negedge clk);
      dig_ready = 1'b0;
    end
    checkOutput("done after last word", {done, busy}, 2'b10);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [127:0] got, exp_d, abs_act, abs_exp;
    bit ok;
    core_lat  = v.lat;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    sendMessage(v.bytes, v.len, ok);
    if (ok) recvDigest(v.stall_word, v.stall_cycles, v.start_word, got, ok);
    if (!ok) begin
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    exp_d = ref_digest(v.bytes, v.len);
    checkOutput("digest", got, exp_d);
    abs_act = '0;
    abs_exp = '0;
    for (int k = 0; k < absorbed.size() && k < 16; k++) abs_act[8*k +: 8] = absorbed[k];
    for (int k = 0; k < v.len; k++) abs_exp[8*k +: 8] = v.bytes[8*k +: 8];
    abs_exp[8*v.len +: 8] = 8'h80;
    checkOutput("absorb count", absorbed.size(), v.exp_absorbs);
    checkOutput("absorb bytes", abs_act, abs_exp);
    checkOutput("squeeze pulses", sqz_pulses, v.exp_sqz);
    @(negedge clk);
    checkOutput("idle after done", {busy, done}, 2'b00);
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   n;
    int   dc;
    bit   ok;
    logic [127:0] unused_got;

    vecs[0] = '{3,  96'h563412,   3, -1, 0,  -1, 4,  15};
    vecs[1] = '{1,  96'hAB,       2, -1, 0,  -1, 2,  15};
    vecs[2] = '{2,  96'hFF01,     2,  2, 20, -1, 3,  15};
    vecs[3] = '{4,  96'hDDCCBBAA, 1, -1, 0,   5, 5,  15};
    vecs[4] = '{12, 96'h0123456789ABCDEF00FF7E81, 5, 7, 3, -1, 13, 15};
    for (int i = 5; i < 10; i++) begin
      vecs[i].len          = $urandom_range(1, 12);
      vecs[i].bytes        = {$urandom, $urandom, $urandom};
      vecs[i].lat          = $urandom_range(1, 5);
      vecs[i].stall_word   = $urandom_range(0, 7);
      vecs[i].stall_cycles = $urandom_range(0, 4);
      vecs[i].start_word   = -1;
      vecs[i].exp_absorbs  = vecs[i].len + 1;
      vecs[i].exp_sqz      = 15;
    end

    reset_n   = 1'b0;
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    msg_data  = '0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_odd   = 1'b0;
    dig_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset values",
                {busy, done, msg_ready, dig_valid, core_start, core_msg_avail, core_reset,
                 dig_data, core_data_in}, {7'b0000001, 24'h0});
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset", {busy, core_reset}, 2'b00);

    for (int i = 0; i < 10; i++) begin
      $display("[TB] vector %0d len=%0d lat=%0d", i, vecs[i].len, vecs[i].lat);
      applyStimulus(vecs[i]);
    end

    // Abort while the core permutes the second message byte.
    $display("[TB] abort sequence");
    core_lat  = 4;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    msg_data  = 16'h3412;
    msg_valid = 1'b1;
    msg_last  = 1'b0;
    msg_odd   = 1'b0;
    n = 0;
    while (!msg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort fetch ready", msg_ready, 1);
    @(negedge clk);
    msg_valid = 1'b0;
    n = 0;
    while (absorbed.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("abort precondition core busy", {core_busy, busy}, 2'b11);
    dc = done_count;
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    checkOutput("abort core_reset", {core_reset, busy, msg_ready, dig_valid}, 4'b1100);
    @(negedge clk);
    checkOutput("abort back to idle", {core_reset, busy}, 2'b00);
    repeat (5) @(negedge clk);
    checkOutput("abort no done", done_count, dc);
    applyStimulus(vecs[0]);

    // Synchronous reset in the middle of the squeeze phase.
    $display("[TB] mid-squeeze reset sequence");
    core_lat  = 2;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    sendMessage(vecs[0].bytes, 3, ok);
    n = 0;
    while (!dig_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first word before reset", dig_valid, 1);
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("core_reset follows reset_n", core_reset, 1);
    @(negedge clk);
    checkOutput("mid-squeeze reset values",
                {busy, done, msg_ready, dig_valid, core_start, core_msg_avail, core_reset,
                 dig_data, core_data_in}, {7'b0000001, 24'h0});
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle after mid reset", {busy, core_reset}, 2'b00);
    applyStimulus(vecs[1]);
    unused_got = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
